// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-coded switch front end.
// Holds the debounce state encoding and the Gray-to-binary conversion.
package gray_pkg;

    localparam int GRAY_WIDTH       = 4;
    localparam int DEBOUNCE_DEFAULT = 16;
    localparam int MAX_W            = 32;

    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } deb_state_t;

    // Prefix XOR from the MSB down; only the low w bits are meaningful.
    function automatic logic [MAX_W-1:0] gray_to_bin(
        input logic [MAX_W-1:0] g,
        input int               w
    );
        logic [MAX_W-1:0] b;
        b = '0;
        for (int i = MAX_W - 1; i >= 0; i--) begin
            if (i == w - 1) begin
                b[i] = g[i];
            end else if (i < w - 1) begin
                b[i] = b[i+1] ^ g[i];
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_input_decoder_sync_2ff.sv
// Two-flop synchronizer for an asynchronous input bus.
// Straight flop-to-flop path with nothing in between.
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= d;
            sync <= meta;
        end
    end

    assign q = sync;

endmodule

// File: rtl/gray_input_decoder.sv
// Switch front end: synchronize, debounce as one word, convert Gray to binary.
// Emits a one-cycle strobe whenever the committed value actually changes.
module gray_input_decoder
    import gray_pkg::*;
#(
    parameter int WIDTH           = GRAY_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] grayIn,
    output logic [WIDTH-1:0] binNumber,
    output logic [WIDTH-1:0] grayStable,
    output logic             newValue,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sample;
    deb_state_t       state;
    deb_state_t       state_d;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] cand_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             commit;
    logic             update;
    logic [WIDTH-1:0] bin_d;

    sync_2ff #(
        .WIDTH(WIDTH)
    ) u_sync (
        .clock(clock),
        .reset(reset),
        .d    (grayIn),
        .q    (sample)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= STABLE;
            cand  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cand  <= cand_d;
            cnt   <= cnt_d;
        end
    end

    // Any movement of the sample while settling restarts the full count.
    always_comb begin
        state_d = state;
        cand_d  = cand;
        cnt_d   = cnt;
        commit  = 1'b0;
        unique case (state)
            STABLE: begin
                if (sample != grayStable) begin
                    state_d = SETTLING;
                    cand_d  = sample;
                    cnt_d   = '0;
                end
            end
            SETTLING: begin
                if (sample != cand) begin
                    cand_d = sample;
                    cnt_d  = '0;
                end else if (cnt == LAST_CNT) begin
                    state_d = STABLE;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
        endcase
    end

    // A commit that lands back on the old word is silent.
    always_comb begin
        update = commit && (cand != grayStable);
        bin_d  = WIDTH'(gray_to_bin(MAX_W'(cand), WIDTH));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grayStable <= '0;
            binNumber  <= '0;
            newValue   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            newValue <= update;
            busy     <= (state_d == SETTLING);
            if (update) begin
                grayStable <= cand;
                binNumber  <= bin_d;
            end
        end
    end

endmodule

// File: tb/tb_gray_input_decoder.sv
// Directed bench for gray_input_decoder with a pulse scoreboard.
// Stimulus queues expected commits; a monitor matches each newValue pulse.
module tb_gray_input_decoder;

    typedef struct {
        logic [3:0] bin;
        logic [3:0] gray;
        int         at;
    } exp_t;

    logic       clock;
    logic       reset;
    logic [3:0] grayIn;
    logic [3:0] binNumber;
    logic [3:0] grayStable;
    logic       newValue;
    logic       busy;

    exp_t exp_q[$];
    int   ncmp;
    int   nerr;
    int   cyc;
    int   busy_seen;
    logic prev_nv;

    gray_input_decoder #(
        .WIDTH          (4),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .grayIn    (grayIn),
        .binNumber (binNumber),
        .grayStable(grayStable),
        .newValue  (newValue),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    function automatic logic [3:0] g2b(input logic [3:0] g);
        return {g[3], g[3] ^ g[2], g[3] ^ g[2] ^ g[1], ^g};
    endfunction

    task automatic chk(input string name, input int act, input int req);
        ncmp++;
        if (act != req) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)",
                     name, act, req, cyc);
        end
    endtask

    task automatic expect_pulse(input logic [3:0] g, input int at);
        exp_t e;
        e.bin  = g2b(g);
        e.gray = g;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Monitor: counts edges, matches pulses, flags missing ones.
    initial begin
        exp_t e;
        cyc     = 0;
        prev_nv = 1'b0;
        forever begin
            @(posedge clock);
            cyc++;
            #1;
            if (newValue) begin
                chk("nv_consecutive", int'(prev_nv), 0);
                chk("nv_conv", int'(binNumber), int'(g2b(grayStable)));
                if (exp_q.size() == 0) begin
                    ncmp++;
                    nerr++;
                    $display("FAIL unexpected_pulse: edge %0d bin=%b gray=%b",
                             cyc, binNumber, grayStable);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_edge", cyc, e.at);
                    chk("pulse_bin", int'(binNumber), int'(e.bin));
                    chk("pulse_gray", int'(grayStable), int'(e.gray));
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].at) begin
                e = exp_q.pop_front();
                ncmp++;
                nerr++;
                $display("FAIL missing_pulse: none by edge %0d expected at %0d",
                         cyc, e.at);
            end
            prev_nv = newValue;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        ncmp   = 0;
        nerr   = 0;
        reset  = 1'b1;
        grayIn = 4'b0000;

        // 1: reset and idle at zero
        wait_cyc(5);
        chk("rst_bin", int'(binNumber), 0);
        chk("rst_gray", int'(grayStable), 0);
        chk("rst_nv", int'(newValue), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (busy) busy_seen++;
        end
        chk("idle_busy_cycles", busy_seen, 0);
        chk("idle_bin", int'(binNumber), 0);

        // 2: 1111 held from reset release
        reset  = 1'b1;
        grayIn = 4'b1111;
        wait_cyc(2);
        reset = 1'b0;
        expect_pulse(4'b1111, cyc + 19);
        wait_cyc(2);
        chk("t2_busy_e2", int'(busy), 0);
        wait_cyc(1);
        chk("t2_busy_e3", int'(busy), 1);
        wait_cyc(20);
        chk("t2_bin", int'(binNumber), 4'b1010);
        chk("t2_gray", int'(grayStable), 4'b1111);
        chk("t2_busy_done", int'(busy), 0);

        // 5: short glitch to 1110 and back
        grayIn = 4'b1110;
        wait_cyc(4);
        chk("t5_busy_on", int'(busy), 1);
        grayIn = 4'b1111;
        wait_cyc(30);
        chk("t5_busy_off", int'(busy), 0);
        chk("t5_bin", int'(binNumber), 4'b1010);

        // 3: two settled values
        grayIn = 4'b0100;
        expect_pulse(4'b0100, cyc + 19);
        wait_cyc(40);
        chk("t3_bin_a", int'(binNumber), 4'b0111);
        grayIn = 4'b0001;
        expect_pulse(4'b0001, cyc + 19);
        wait_cyc(40);
        chk("t3_bin_b", int'(binNumber), 4'b0001);

        // 6: reset in the middle of a settle
        grayIn = 4'b1000;
        wait_cyc(9);
        @(posedge clock);
        #3;
        chk("t6_busy_pre", int'(busy), 1);
        reset = 1'b1;
        #1;
        chk("t6_async_bin", int'(binNumber), 0);
        chk("t6_async_gray", int'(grayStable), 0);
        chk("t6_async_busy", int'(busy), 0);
        chk("t6_async_nv", int'(newValue), 0);
        wait_cyc(2);
        reset = 1'b0;
        expect_pulse(4'b1000, cyc + 19);
        wait_cyc(30);
        chk("t6_bin", int'(binNumber), 4'b1111);

        // 4: bounce between 0000 and 0001, then hold 0001
        reset  = 1'b1;
        grayIn = 4'b0000;
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(10);
        for (int i = 0; i < 20; i++) begin
            grayIn = (i % 2 == 1) ? 4'b0001 : 4'b0000;
            if (i == 19) expect_pulse(4'b0001, cyc + 19);
            wait_cyc(5);
        end
        wait_cyc(35);
        chk("t4_bin", int'(binNumber), 4'b0001);
        chk("t4_gray", int'(grayStable), 4'b0001);

        wait_cyc(2);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/gray_input_decoder.md
Name: gray_input_decoder

Overview:
- Front-end stage that feeds the LED binary display. It captures the 4 slide-switch inputs, which carry a Gray-coded value.
- It synchronizes the switches to the clock, debounces them as one word, converts the value to binary, and presents a registered binNumber plus an update strobe.
- Its binNumber output connects directly to the display stage's binNumber input.

Parameters:
- WIDTH, 4: Gray/binary word width.
- DEBOUNCE_CYCLES, 16: consecutive stable clock cycles required before a new value is committed. Minimum 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): debounce counter width. Derived; do not override.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- grayIn  in  WIDTH  raw switch inputs, Gray code, asynchronous to clock.
- binNumber  out  WIDTH  registered binary value of the last committed Gray word.
- grayStable  out  WIDTH  last committed (debounced) Gray word.
- newValue  out  1  one-cycle pulse on the edge where binNumber/grayStable take a new, different value.
- busy  out  1  high while in SETTLING.

Behaviour:
- Reset: asynchronous, active-high, applies immediately.
  - Sync flops, candidate, counter, grayStable, binNumber, newValue and busy all go to 0.
  - State goes to STABLE.
  - Reset mid-SETTLING aborts the settle with no newValue pulse.
- Synchronizer:
  - Each grayIn bit passes through a 2-flop chain.
  - sample = second-stage output.
  - No logic is allowed between the two flops.
- FSM states: STABLE, SETTLING. busy = (state == SETTLING), registered.
  - STABLE, sample == grayStable: stay in STABLE.
  - STABLE, sample != grayStable: go to SETTLING; candidate <= sample; cnt <= 0.
  - SETTLING, sample != candidate: restart; candidate <= sample; cnt <= 0; stay in SETTLING.
  - SETTLING, sample == candidate, cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - SETTLING, sample == candidate, cnt == DEBOUNCE_CYCLES-1: commit and return to STABLE.
    - If candidate != grayStable: grayStable <= candidate; binNumber <= gray_to_bin(candidate); newValue <= 1.
    - If candidate == grayStable (input bounced back): no output change and no pulse.
- newValue is 0 on every other edge. It is never high on two consecutive edges.
- Conversion: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i] for i = WIDTH-2 down to 0. Pure XOR, no carries.
- Latency, input changing once and then held, edges counted after the input change:
  - Edge 2: sample changes.
  - Edge 3: SETTLING entered.
  - Edge 3+DEBOUNCE_CYCLES: commit. With the default that is edge 19, i.e. 380 ns at a 20 ns clock period.
- Any change of sample during SETTLING restarts the full count. Latency is measured from the last change.
- A non-zero grayIn held through reset release is debounced normally and produces one newValue pulse.
- binNumber and grayStable always change together on the same edge.
- The counter must never wrap: it is held at DEBOUNCE_CYCLES-1 at most.

Decomposition:
- Package gray_pkg:
  - typedef enum logic {STABLE, SETTLING} deb_state_t.
  - Function gray_to_bin(parameterized width).
  - Default constants GRAY_WIDTH = 4 and DEBOUNCE_DEFAULT = 16.
- One sub-module, sync_2ff:
  - Parameter WIDTH.
  - Ports clock, reset, d, q.
  - Async active-high reset to 0.
  - Instantiated once for the whole grayIn bus.
- The FSM, counter and output registers stay in gray_input_decoder.

Test Plan:
1. Reset asserted 5 cycles with grayIn=4'b0000, then released and held 50 cycles -> binNumber=0, grayStable=0, newValue and busy never high.
2. grayIn=4'b1111 held from reset release -> busy high from edge 3; edge 19: binNumber=4'b1010, grayStable=4'b1111, newValue high for exactly one cycle.
3. Sequence 4'b0100 then 4'b0001, each held 40 cycles -> binNumber=4'b0111, then 4'b0001. Exactly two newValue pulses, each 19 edges after its change.
4. Bounce: grayIn alternates 4'b0000/4'b0001 every 5 cycles for 100 cycles, then holds 4'b0001 -> no pulse during toggling. One pulse 19 edges after the last change; binNumber=4'b0001.
5. Glitch: from stable 4'b1111, drive 4'b1110 for 4 cycles then back to 4'b1111 -> busy asserts then clears. No newValue pulse; binNumber stays 4'b1010.
6. Reset mid-settle: grayIn=4'b1000, assert reset at edge 10 -> all outputs 0 immediately (asynchronous) and no pulse. After release, value re-debounces: binNumber=4'b1111 at edge 19 after release.
